// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch with one outstanding memory
// request, a DEPTH-entry in-order {pc, inst} queue and branch redirect.
// Ports: clk/reset; redirect, redirect_pc from EX/MEM;
//        imem_req/addr/ready/rvalid/rdata to instruction memory;
//        inst_valid/inst/inst_pc/inst_ready to decode; count = occupancy.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         redirect,
    input  logic [63:0]                  redirect_pc,
    output logic                         imem_req,
    output logic [63:0]                  imem_addr,
    input  logic                         imem_ready,
    input  logic                         imem_rvalid,
    input  logic [31:0]                  imem_rdata,
    output logic                         inst_valid,
    output logic [31:0]                  inst,
    output logic [63:0]                  inst_pc,
    input  logic                         inst_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DROP
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [63:0]     fetch_pc;
    logic [63:0]     req_pc;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [63:0]     pc_mem   [DEPTH];
    logic [31:0]     inst_mem [DEPTH];
    logic            issue;
    logic            push;
    logic            pop;

    assign imem_addr  = fetch_pc;
    assign inst_valid = (count != '0);
    assign inst       = inst_mem[rd_ptr];
    assign inst_pc    = pc_mem[rd_ptr];

    assign issue = imem_req & imem_ready;
    // A redirect in the response cycle discards that response.
    assign push  = (state == S_WAIT) & imem_rvalid & ~redirect;
    assign pop   = inst_valid & inst_ready & ~redirect;

    always_comb begin
        state_nx = state;
        imem_req = 1'b0;
        unique case (state)
            S_IDLE:  state_nx = S_FETCH;
            S_FETCH: begin
                imem_req = (count < CW'(DEPTH)) & ~redirect;
                if (imem_req & imem_ready)
                    state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid)
                    state_nx = S_FETCH;
                else if (redirect)
                    state_nx = S_DROP;
            end
            S_DROP: begin
                if (imem_rvalid)
                    state_nx = S_FETCH;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            state <= state_nx;
            if (issue)
                req_pc <= fetch_pc;
            if (redirect) begin
                fetch_pc <= redirect_pc & ~64'h3;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (issue)
                    fetch_pc <= fetch_pc + 64'd4;
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Queue storage needs no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= req_pc;
            inst_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule
